// File: rtl/wired_rob_wb_if.sv
// CDB payload type and the dispatch/writeback/commit bundle seen by the
// banked ROB completion store.
package wired_rob_wb_pkg;
   localparam int CDB_WID_W  = 6;
   localparam int CDB_DATA_W = 64;

   typedef struct packed {
      logic                  valid;
      logic [CDB_WID_W-1:0]  wid;
      logic [CDB_DATA_W-1:0] result;
   } pipeline_cdb_t;
endpackage

interface wired_rob_wb_if #(
   parameter int WID_W  = 6,
   parameter int INFO_W = 64
);
   logic                                 flush_i;
   logic [1:0]                           dispatch_valid_i;
   logic [1:0][INFO_W-1:0]               dispatch_info_i;
   logic                                 dispatch_ready_o;
   logic [1:0][WID_W-1:0]                dispatch_wid_o;
   wired_rob_wb_pkg::pipeline_cdb_t [1:0] cdb_i;
   logic [1:0]                           commit_valid_o;
   logic [1:0]                           commit_ready_i;
   logic [1:0][WID_W-1:0]                commit_wid_o;
   logic [1:0][INFO_W-1:0]               commit_info_o;
   wired_rob_wb_pkg::pipeline_cdb_t [1:0] commit_cdb_o;
   logic [WID_W:0]                       count_o;

   modport master (
      output flush_i, dispatch_valid_i, dispatch_info_i, cdb_i, commit_ready_i,
      input  dispatch_ready_o, dispatch_wid_o, commit_valid_o, commit_wid_o,
             commit_info_o, commit_cdb_o, count_o
   );

   modport slave (
      input  flush_i, dispatch_valid_i, dispatch_info_i, cdb_i, commit_ready_i,
      output dispatch_ready_o, dispatch_wid_o, commit_valid_o, commit_wid_o,
             commit_info_o, commit_cdb_o, count_o
   );
endinterface

// File: rtl/wired_rob_wb.sv
// Banked reorder-buffer completion store: in-order allocation, one CDB
// writeback per bank per cycle, two-wide in-order commit window.
module wired_rob_wb #(
   parameter int ROB_DEPTH = 64,
   parameter int WID_W     = $clog2(ROB_DEPTH),
   parameter int INFO_W    = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   wired_rob_wb_if.slave bus
);
   import wired_rob_wb_pkg::*;

   localparam int BANK_D = ROB_DEPTH / 2;

   logic [WID_W-1:0]     head_q, tail_q, head_p1, tail_p1;
   logic [WID_W:0]       count_q;
   logic [ROB_DEPTH-1:0] done_q, done_nxt;

   logic [INFO_W-1:0]    info_mem [2][BANK_D];
   pipeline_cdb_t        cdb_mem  [2][BANK_D];

   logic                 dispatch_ready;
   logic [1:0]           commit_valid;
   logic [1:0]           alloc_en, pop_en;
   logic [1:0]           n_alloc, n_pop;
   logic [1:0]           bank_we;
   logic [WID_W-2:0]     bank_idx  [2];
   logic [INFO_W-1:0]    bank_info [2];
   logic [WID_W-1:0]     wb_ent [2];
   logic [WID_W-1:0]     wb_ofs [2];
   logic [1:0]           wb_legal;

   assign head_p1 = head_q + 1'b1;
   assign tail_p1 = tail_q + 1'b1;

   assign dispatch_ready  = (count_q <= (WID_W+1)'(ROB_DEPTH-2));
   assign commit_valid[0] = (count_q != '0) && done_q[head_q];
   assign commit_valid[1] = commit_valid[0] && (count_q >= (WID_W+1)'(2)) && done_q[head_p1];

   always_comb begin
      alloc_en  = bus.dispatch_valid_i & {2{dispatch_ready}};
      pop_en[0] = commit_valid[0] & bus.commit_ready_i[0];
      pop_en[1] = commit_valid[1] & bus.commit_ready_i[1] & bus.commit_ready_i[0];
      n_alloc   = {1'b0, alloc_en[0]} + {1'b0, alloc_en[1]};
      n_pop     = {1'b0, pop_en[0]} + {1'b0, pop_en[1]};
   end

   // tail and tail+1 always sit in opposite banks, so each bank sees at most
   // one allocation; bank b takes slot0 when tail_q[0]==b, otherwise slot1.
   always_comb begin
      bank_we = '0;
      for (int unsigned b = 0; b < 2; b++) begin
         bank_idx[b]  = '0;
         bank_info[b] = '0;
         if ((1'(b) ^ tail_q[0]) == 1'b0) begin
            bank_we[b]   = alloc_en[0];
            bank_idx[b]  = tail_q[WID_W-1:1];
            bank_info[b] = bus.dispatch_info_i[0];
         end else begin
            bank_we[b]   = alloc_en[1];
            bank_idx[b]  = tail_p1[WID_W-1:1];
            bank_info[b] = bus.dispatch_info_i[1];
         end
      end
   end

   always_comb begin
      wb_ent[0] = {bus.cdb_i[0].wid[WID_W-1:1], 1'b0};
      wb_ent[1] = {bus.cdb_i[1].wid[WID_W-1:1], 1'b1};
      for (int unsigned b = 0; b < 2; b++) begin
         wb_ofs[b]   = wb_ent[b] - head_q;
         wb_legal[b] = ({1'b0, wb_ofs[b]} < count_q);
      end
   end

   always_comb begin
      done_nxt = done_q;
      if (alloc_en[0]) done_nxt[tail_q]  = 1'b0;
      if (alloc_en[1]) done_nxt[tail_p1] = 1'b0;
      if (pop_en[0])   done_nxt[head_q]  = 1'b0;
      if (pop_en[1])   done_nxt[head_p1] = 1'b0;
      for (int unsigned b = 0; b < 2; b++) begin
         if (bus.cdb_i[b].valid) done_nxt[wb_ent[b]] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         done_q  <= '0;
      end else if (bus.flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         done_q  <= '0;
      end else begin
         head_q  <= head_q + WID_W'(n_pop);
         tail_q  <= tail_q + WID_W'(n_alloc);
         count_q <= count_q + (WID_W+1)'(n_alloc) - (WID_W+1)'(n_pop);
         done_q  <= done_nxt;
      end
   end

   // Payload storage carries no reset; done_q alone decides what is live.
   always_ff @(posedge clk) begin
      if (!bus.flush_i) begin
         for (int unsigned b = 0; b < 2; b++) begin
            if (bank_we[b]) info_mem[b][bank_idx[b]] <= bank_info[b];
            if (bus.cdb_i[b].valid) cdb_mem[b][bus.cdb_i[b].wid[WID_W-1:1]] <= bus.cdb_i[b];
         end
      end
   end

   assign bus.dispatch_ready_o  = dispatch_ready;
   assign bus.dispatch_wid_o[0] = tail_q;
   assign bus.dispatch_wid_o[1] = tail_p1;
   assign bus.commit_valid_o    = commit_valid;
   assign bus.commit_wid_o[0]   = head_q;
   assign bus.commit_wid_o[1]   = head_p1;
   assign bus.commit_info_o[0]  = info_mem[head_q[0]][head_q[WID_W-1:1]];
   assign bus.commit_info_o[1]  = info_mem[head_p1[0]][head_p1[WID_W-1:1]];
   assign bus.commit_cdb_o[0]   = cdb_mem[head_q[0]][head_q[WID_W-1:1]];
   assign bus.commit_cdb_o[1]   = cdb_mem[head_p1[0]][head_p1[WID_W-1:1]];
   assign bus.count_o           = count_q;

   a_dispatch_pattern: assert property (@(posedge clk) disable iff (!rst_n || bus.flush_i)
      bus.dispatch_valid_i != 2'b10);
   a_wb0_allocated: assert property (@(posedge clk) disable iff (!rst_n || bus.flush_i)
      !bus.cdb_i[0].valid || (wb_legal[0] && !bus.cdb_i[0].wid[0]));
   a_wb1_allocated: assert property (@(posedge clk) disable iff (!rst_n || bus.flush_i)
      !bus.cdb_i[1].valid || (wb_legal[1] && bus.cdb_i[1].wid[0]));
endmodule
